// File: rtl/gray_code_converter_seq.sv
// gray_code_converter_seq: bit-serial MSB-first binary<->Gray converter behind valid/ready handshakes
module gray_code_converter_seq #(
  parameter int WIDTH = 4,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d, out_q, out_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d, prev_q, prev_d, bit_c;
  assign bit_c = d_q[idx_q] ^ prev_q;
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    out_d   = out_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE: if (in_valid) begin
        d_d     = in_data;
        mode_d  = in_mode;
        idx_d   = CNT_W'(WIDTH - 1);
        prev_d  = 1'b0;
        out_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        out_d[idx_q] = bit_c;
        // binary->Gray chains on the input bit, Gray->binary on the produced bit
        prev_d  = mode_q ? bit_c : d_q[idx_q];
        idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
        state_d = (idx_q == '0) ? DONE : CONV;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      prev_q  <= prev_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = out_q;
endmodule

// File: tb/tb_gray_code_converter_seq.sv
// tb_gray_code_converter_seq: vector table, sweeps, corner sequences and random words for WIDTH 4, 8 and 1
module tb_gray_code_converter_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv4 = 0, ir4, im4 = 0, ov4, or4 = 0, b4;
  logic [3:0] id4 = 0, od4;
  logic iv8 = 0, ir8, im8 = 0, ov8, or8 = 0, b8;
  logic [7:0] id8 = 0, od8;
  logic iv1 = 0, ir1, im1 = 0, ov1, or1 = 0, b1;
  logic [0:0] id1 = 0, od1;
  int n_chk = 0, n_fail = 0;
  gray_code_converter_seq #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_data(id4), .in_mode(im4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(b4));
  gray_code_converter_seq #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_data(id8), .in_mode(im8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(b8));
  gray_code_converter_seq #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .in_mode(im1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(b1));
  typedef struct {
    logic [3:0] d;
    logic       m;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[5];
  function automatic logic [31:0] to_gray(logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] to_bin(logic [31:0] g);
    logic [31:0] r = 0;
    for (int i = 0; i < 32; i++) r ^= g >> i;
    return r;
  endfunction
  function automatic logic [31:0] ref_conv(logic [31:0] d, logic m);
    return m ? to_bin(d) : to_gray(d);
  endfunction
  function automatic logic p_ov(int w);
    return w == 8 ? ov8 : w == 1 ? ov1 : ov4;
  endfunction
  function automatic logic p_ir(int w);
    return w == 8 ? ir8 : w == 1 ? ir1 : ir4;
  endfunction
  function automatic logic p_busy(int w);
    return w == 8 ? b8 : w == 1 ? b1 : b4;
  endfunction
  function automatic logic [31:0] p_od(int w);
    return w == 8 ? 32'(od8) : w == 1 ? 32'(od1) : 32'(od4);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_in(int w, logic v, logic [31:0] d, logic m);
    if (w == 8) begin iv8 = v; id8 = d[7:0]; im8 = m; end
    else if (w == 1) begin iv1 = v; id1 = d[0:0]; im1 = m; end
    else begin iv4 = v; id4 = d[3:0]; im4 = m; end
  endtask
  task automatic set_ordy(int w, logic v);
    if (w == 8) or8 = v; else if (w == 1) or1 = v; else or4 = v;
  endtask
  // one word: accept, wait for result, hold in DONE for 'hold' cycles, then hand it off
  task automatic xfer(int w, logic [31:0] d, logic m, int hold, output logic [31:0] r);
    int lat = 0;
    chk("ready_before", 32'(p_ir(w)), 1);
    set_in(w, 1'b1, d, m);
    @(posedge clk); #1;
    set_in(w, 1'b0, $urandom, ~m);
    chk("busy_conv", {p_ir(w), p_busy(w)}, 2'b01);
    while (!p_ov(w) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, w);
    r = p_od(w);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {p_ov(w), p_ir(w), p_od(w)}, {1'b1, 1'b0, r});
    end
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
    chk("after_hs", {p_ov(w), p_ir(w), p_busy(w)}, 3'b010);
  endtask
  logic [31:0] r, g, b;
  int hits[$];
  initial begin
    tbl = '{'{4'b1011, 1'b0, 4'b1110}, '{4'b1110, 1'b1, 4'b1011}, '{4'b0110, 1'b0, 4'b0101},
            '{4'b0000, 1'b1, 4'b0000}, '{4'b1111, 1'b0, 4'b1000}};
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_state", {ir4, ov4, b4, od4}, {3'b100, 4'h0});
    foreach (tbl[i]) begin
      xfer(4, 32'(tbl[i].d), tbl[i].m, 0, r);
      chk("table", r, 32'(tbl[i].exp));
    end
    for (int v = 0; v < 16; v++) begin
      xfer(4, v, 1'b0, 0, g);
      chk("sweep_b2g", g, to_gray(v));
      xfer(4, g, 1'b1, 0, b);
      chk("round_trip", b, v);
      xfer(4, v, 1'b1, 0, r);
      chk("sweep_g2b", r, to_bin(v));
    end
    // backpressure: new word offered during DONE and during the handoff edge must be ignored
    set_in(4, 1'b1, 4'b1011, 1'b0);
    @(posedge clk); #1;
    set_in(4, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", {ov4, od4}, {1'b1, 4'b1110});
    set_in(4, 1'b1, 4'b0101, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {ov4, ir4, b4, od4}, {3'b101, 4'b1110});
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    set_in(4, 1'b0, 0, 0);
    chk("bp_release", {ir4, ov4, b4}, 3'b100);
    // asynchronous reset in the middle of a conversion
    set_in(4, 1'b1, 4'b0110, 1'b0);
    @(posedge clk); #1;
    set_in(4, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {ir4, ov4, b4, od4}, {3'b100, 4'h0});
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {ir4, ov4, b4}, 3'b100);
    xfer(4, 4'b0110, 1'b0, 0, r);
    chk("post_reset_word", r, 4'b0101);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] d = 4'($urandom_range(0, 15));
      logic m = 1'($urandom_range(0, 1));
      xfer(4, d, m, $urandom_range(0, 3), r);
      chk("random", r, ref_conv(d, m));
    end
    xfer(8, 8'hFF, 1'b1, 1, r);
    chk("w8_g2b_ff", r, 8'hAA);
    xfer(8, 8'h80, 1'b0, 0, r);
    chk("w8_b2g_80", r, 8'hC0);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d = 8'($urandom);
      logic m = 1'($urandom_range(0, 1));
      xfer(8, d, m, 0, r);
      chk("w8_random", r, ref_conv(d, m));
    end
    xfer(1, 1, 1'b0, 0, r);
    chk("w1_mode0", r, 1);
    xfer(1, 1, 1'b1, 0, r);
    chk("w1_mode1", r, 1);
    xfer(1, 0, 1'b1, 0, r);
    chk("w1_zero", r, 0);
    // back-to-back single-bit words with the consumer always ready
    or1 = 1'b1;
    set_in(1, 1'b1, 1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ov1) begin
        hits.push_back(k);
        chk("w1_b2b_data", od1, 1);
      end
    end
    set_in(1, 1'b0, 0, 0);
    or1 = 1'b0;
    chk("w1_b2b_count", hits.size(), 4);
    for (int i = 1; i < hits.size(); i++) chk("w1_b2b_period", hits[i] - hits[i-1], 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
